// File: rtl/prog_loader.sv
// prog_loader
//   UART-fed program loader driving the write port of the instruction memory.
//   A framed image (0xA5, N, 4*N data bytes MSB first, XOR checksum) is
//   received on rx and written word by word from address 0. The processor is
//   held in reset until a checksum-verified image has been loaded.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high reset
//   rx         in   UART serial input, idle high, asynchronous to clk
//   mem_we     out  instruction memory write strobe (one cycle per word)
//   mem_addr   out  word address of the write
//   mem_wd     out  instruction word of the write
//   cpu_reset  out  processor reset, high while no valid image is loaded
//   done       out  high after a successful load
//   error      out  high after a failed load
module prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int          CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int          HALF      = CLKS_PER_BIT / 2;
    localparam int          NW        = ADDR_W + 1;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERR} fr_state_t;

    // ------------------------------------------------------------------
    // rx synchroniser; rx_prev gives the previous synchronised sample for
    // falling-edge detection of the start bit.
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       rx_shift, rx_shift_n;
    logic             byte_valid, byte_valid_n;
    logic [7:0]       byte_data, byte_data_n;
    logic             frame_err, frame_err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            rx_shift   <= rx_shift_n;
            byte_valid <= byte_valid_n;
            byte_data  <= byte_data_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        clk_cnt_n    = clk_cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        rx_shift_n   = rx_shift;
        byte_valid_n = 1'b0;
        byte_data_n  = byte_data;
        frame_err_n  = 1'b0;

        case (rx_state)
            RX_IDLE: begin
                clk_cnt_n = '0;
                if (rx_prev && !rx_sync)
                    rx_state_n = RX_START;
            end
            RX_START: begin
                // Mid-bit check of the start bit; high here means a glitch.
                if (clk_cnt == CNT_W'(HALF - 1)) begin
                    clk_cnt_n = '0;
                    if (rx_sync) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        bit_idx_n  = '0;
                    end
                end
            end
            RX_DATA: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n  = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    bit_idx_n  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7)
                        rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n  = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_sync) begin
                        byte_valid_n = 1'b1;
                        byte_data_n  = rx_shift;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser and memory write side
    // ------------------------------------------------------------------
    fr_state_t         f_state, f_state_n;
    logic [NW-1:0]     n_words, n_words_n;
    logic [ADDR_W-1:0] word_idx, word_idx_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [31:0]       word_sr, word_sr_n;
    logic [7:0]        csum, csum_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [31:0]       mem_wd_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_state  <= IDLE;
            n_words  <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_sr  <= '0;
            csum     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
        end else begin
            f_state  <= f_state_n;
            n_words  <= n_words_n;
            word_idx <= word_idx_n;
            byte_cnt <= byte_cnt_n;
            word_sr  <= word_sr_n;
            csum     <= csum_n;
            mem_we   <= mem_we_n;
            mem_addr <= mem_addr_n;
            mem_wd   <= mem_wd_n;
        end
    end

    always_comb begin
        f_state_n  = f_state;
        n_words_n  = n_words;
        word_idx_n = word_idx;
        byte_cnt_n = byte_cnt;
        word_sr_n  = word_sr;
        csum_n     = csum;
        mem_we_n   = 1'b0;
        mem_addr_n = mem_addr;
        mem_wd_n   = mem_wd;

        case (f_state)
            IDLE: begin
                if (byte_valid && byte_data == SYNC_BYTE)
                    f_state_n = LEN;
            end
            LEN: begin
                if (frame_err) begin
                    f_state_n = ERR;
                end else if (byte_valid) begin
                    if (byte_data == 8'd0 || 32'(byte_data) > MAX_WORDS) begin
                        f_state_n = ERR;
                    end else begin
                        n_words_n  = NW'(byte_data);
                        word_idx_n = '0;
                        byte_cnt_n = '0;
                        word_sr_n  = '0;
                        csum_n     = '0;
                        f_state_n  = DATA;
                    end
                end
            end
            DATA: begin
                if (frame_err) begin
                    f_state_n = ERR;
                end else if (byte_valid) begin
                    word_sr_n  = {word_sr[23:0], byte_data};
                    csum_n     = csum ^ byte_data;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        mem_we_n   = 1'b1;
                        mem_addr_n = word_idx;
                        mem_wd_n   = {word_sr[23:0], byte_data};
                        word_idx_n = word_idx + ADDR_W'(1);
                        if ({1'b0, word_idx} == n_words - NW'(1))
                            f_state_n = CSUM;
                    end
                end
            end
            CSUM: begin
                if (frame_err)
                    f_state_n = ERR;
                else if (byte_valid)
                    f_state_n = (byte_data == csum) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (byte_valid && byte_data == SYNC_BYTE)
                    f_state_n = LEN;
            end
            default: f_state_n = IDLE;
        endcase
    end

    assign done      = (f_state == DONE);
    assign error     = (f_state == ERR);
    assign cpu_reset = (f_state != DONE);

endmodule
